// File: rtl/debounce_sync.sv
`timescale 1ns/1ps
// debounce_sync: synchronizes an asynchronous, bouncing input and accepts a
// new level only after it has been seen for DEBOUNCE_CYCLES consecutive
// enabled cycles. Emits the clean level plus one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer chain shifts every cycle, independent of en.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state, counter and output qualification logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if ((sync_out != q_q) && en) begin
          state_d = CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (en) begin
          if (sync_out == q_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            q_d     = sync_out;
            rise_d  = sync_out;
            fall_d  = ~sync_out;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == CHECK);

endmodule

// File: tb/tb_debounce_sync.sv
`timescale 1ns/1ps
// Testbench for debounce_sync: scenario tasks push expected observations
// (cycle index, q, rise, fall, busy) and pop/compare them one ns after each
// rising edge.
module tb_debounce_sync;

  logic clk, rst, din, en;
  logic q, rise, fall, busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   cyc;
    logic q;
    logic r;
    logic f;
    logic b;
    bit   chk_b;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  debounce_sync #(
    .SYNC_STAGES(2),
    .CNT_WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .RESET_VALUE(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .en  (en),
    .q   (q),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(int cyc, logic eq, logic er, logic ef, logic eb, bit chk_b);
    exp_t x;
    x.cyc = cyc; x.q = eq; x.r = er; x.f = ef; x.b = eb; x.chk_b = chk_b;
    sb.push_back(x);
  endfunction

  // Reset applies asynchronously and holds while rst is low.
  task automatic test_reset();
    #3;
    push(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({q, rise, fall, busy} !== {e.q, e.r, e.f, e.b}) begin
      n_bad++;
      $display("FAIL reset_async: got q/r/f/b=%b%b%b%b want %b%b%b%b", q, rise, fall, busy, e.q, e.r, e.f, e.b);
    end
    repeat (2) @(posedge clk);
    #1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({q, rise, fall, busy} !== {e.q, e.r, e.f, e.b}) begin
      n_bad++;
      $display("FAIL reset_hold: got q/r/f/b=%b%b%b%b want %b%b%b%b", q, rise, fall, busy, e.q, e.r, e.f, e.b);
    end
    @(negedge clk);
    din = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({q, rise, fall, busy} !== {e.q, e.r, e.f, e.b}) begin
      n_bad++;
      $display("FAIL reset_idle: got q/r/f/b=%b%b%b%b want %b%b%b%b", q, rise, fall, busy, e.q, e.r, e.f, e.b);
    end
  endtask

  // Clean 0->1: busy from edge 3, q/rise at edge 10.
  task automatic test_clean_rise();
    @(negedge clk);
    din = 1'b1;
    for (int c = 1; c <= 12; c++)
      push(c, c >= 10, c == 10, 1'b0, (c >= 3 && c <= 9), 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL clean_rise c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
    end
  endtask

  // Clean 1->0: fall pulse at edge 10.
  task automatic test_clean_fall();
    @(negedge clk);
    din = 1'b0;
    for (int c = 1; c <= 12; c++)
      push(c, c < 10, 1'b0, c == 10, (c >= 3 && c <= 9), 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL clean_fall c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
    end
  endtask

  // Five-cycle pulse on din is rejected; busy spans edges 3..7.
  task automatic test_glitch();
    @(negedge clk);
    din = 1'b1;
    for (int c = 1; c <= 12; c++)
      push(c, 1'b0, 1'b0, 1'b0, (c >= 3 && c <= 7), 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL glitch c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
      if (c == 5) din = 1'b0;
    end
  endtask

  // en low for edges 7..10 pauses qualification; q rises at edge 14, then falls back.
  task automatic test_enable_pause();
    @(negedge clk);
    din = 1'b1;
    for (int c = 1; c <= 16; c++)
      push(c, c >= 14, c == 14, 1'b0, (c >= 3 && c <= 13), 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL enable_pause c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
      if (c == 6)  en = 1'b0;
      if (c == 10) en = 1'b1;
    end
    @(negedge clk);
    din = 1'b0;
    for (int c = 1; c <= 12; c++)
      push(c, c < 10, 1'b0, c == 10, (c >= 3 && c <= 9), 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL pause_refall c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
    end
  endtask

  // Reset pulse after edge 7 discards the candidate; requalifies from scratch.
  task automatic test_reset_mid();
    @(negedge clk);
    din = 1'b1;
    for (int c = 1; c <= 7; c++)
      push(c, 1'b0, 1'b0, 1'b0, (c >= 3), 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL reset_mid_pre c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
    end
    rst = 1'b0;
    #1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({q, rise, fall, busy} !== {e.q, e.r, e.f, e.b}) begin
      n_bad++;
      $display("FAIL reset_mid_async: got q/r/f/b=%b%b%b%b want %b%b%b%b", q, rise, fall, busy, e.q, e.r, e.f, e.b);
    end
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 12; c++)
      push(c, c >= 10, c == 10, 1'b0, (c >= 3 && c <= 9), 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL reset_mid_post c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
    end
  endtask

  // din toggling every cycle never changes q; busy unchecked until settled.
  task automatic test_toggle();
    @(negedge clk);
    din = 1'b0;
    for (int c = 1; c <= 26; c++)
      push(c, 1'b1, 1'b0, 1'b0, 1'b0, c == 26);
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL toggle c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
      if (c < 20)  din = ~din;
      if (c == 20) din = 1'b1;
    end
  endtask

  // din reverts right before the qualifying edge: fall still accepted at
  // edge 10, then the lagging revert requalifies into a rise at edge 19.
  task automatic test_late_revert();
    @(negedge clk);
    din = 1'b0;
    for (int c = 1; c <= 20; c++)
      push(c, (c < 10) || (c >= 19), c == 19, c == 10,
           (c >= 3 && c <= 9) || (c >= 12 && c <= 18), 1'b1);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ({q, rise, fall} !== {e.q, e.r, e.f} || (e.chk_b && busy !== e.b)) begin
          n_bad++;
          $display("FAIL late_revert c=%0d: got q/r/f/b=%b%b%b%b want %b%b%b%b", c, q, rise, fall, busy, e.q, e.r, e.f, e.b);
        end
      end
      if (c == 9) din = 1'b1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    din = 1'b1;
    en  = 1'b1;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_enable_pause();
    test_reset_mid();
    test_toggle();
    test_late_revert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
